// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch reset address, ISA opcode/funct constants
// and the {pc, instr} entry type passed between fetch stages.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  // Word-addressed PC advance; wraps modulo 2^32.
  function automatic addr_t pc_add(input addr_t pc, input addr_t step);
    return pc + step;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory select/data, control from execute/decode, and the
// registered instruction handed to decode.
interface instruction_fetch_if;
  import cpu_pkg::*;

  addr_t  imem_sel;
  instr_t imem_data;
  logic   stall;
  logic   redirect;
  addr_t  redirect_target;
  instr_t instr;
  addr_t  instr_pc;
  logic   instr_valid;

  modport master (
    output imem_sel, instr, instr_pc, instr_valid,
    input  imem_data, stall, redirect, redirect_target
  );

  modport slave (
    input  imem_sel, instr, instr_pc, instr_valid,
    output imem_data, stall, redirect, redirect_target
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding buffer. Catches the word already in flight from memory
// when decode back-pressures, so nothing is lost or refetched.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t in_entry,
  output logic         valid,
  output fetch_entry_t out_entry
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      if (pop) begin
        valid_d = 1'b0;
      end
      // A full, non-draining entry is never overwritten.
      if (push && (!valid_q || pop)) begin
        valid_d = 1'b1;
        entry_d = in_entry;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid     = valid_q;
  assign out_entry = entry_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, hides the one-cycle synchronous memory latency, absorbs
// decode stalls via a skid entry, and restarts on redirect.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC  = DEFAULT_RESET_PC,
  parameter addr_t ADDR_STEP = 32'd1
) (
  input logic                 clock,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  addr_t  fetch_pc_q, fetch_pc_d;
  logic   pend_valid_q, pend_valid_d;
  addr_t  pend_pc_q, pend_pc_d;
  instr_t instr_q, instr_d;
  addr_t  instr_pc_q, instr_pc_d;
  logic   instr_valid_q, instr_valid_d;

  logic         accept;
  logic         skid_valid;
  fetch_entry_t skid_entry;
  logic         skid_push, skid_pop, skid_flush;
  logic         skid_full_next;

  fetch_skid_buffer u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (skid_flush),
    .push      (skid_push),
    .pop       (skid_pop),
    .in_entry  ('{pc: pend_pc_q, instr: bus.imem_data}),
    .valid     (skid_valid),
    .out_entry (skid_entry)
  );

  always_comb begin
    accept         = !instr_valid_q || !bus.stall;
    fetch_pc_d     = fetch_pc_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instr_valid_d  = instr_valid_q;
    skid_push      = 1'b0;
    skid_pop       = 1'b0;
    skid_flush     = 1'b0;
    skid_full_next = 1'b0;

    if (bus.redirect) begin
      // Squash everything, including a stalled output; issue the target next edge.
      fetch_pc_d    = bus.redirect_target;
      pend_valid_d  = 1'b0;
      instr_valid_d = 1'b0;
      skid_flush    = 1'b1;
    end else begin
      if (accept) begin
        if (skid_valid) begin
          instr_d       = skid_entry.instr;
          instr_pc_d    = skid_entry.pc;
          instr_valid_d = 1'b1;
          skid_pop      = 1'b1;
        end else if (pend_valid_q) begin
          instr_d       = bus.imem_data;
          instr_pc_d    = pend_pc_q;
          instr_valid_d = 1'b1;
        end else begin
          instr_valid_d = 1'b0;
        end
      end

      // The memory word is only on imem_data this cycle; park it if it was not consumed.
      skid_push      = pend_valid_q && (!accept || skid_valid);
      skid_full_next = skid_push || (skid_valid && !skid_pop);

      if (!skid_full_next) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = fetch_pc_q;
        fetch_pc_d   = pc_add(fetch_pc_q, ADDR_STEP);
      end else begin
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.imem_sel    = fetch_pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random stall/redirect traffic,
// checked against a stream-level model of the fetch front end.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic clock;
  logic reset;
  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC  (ResetPc),
    .ADDR_STEP (32'd1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_rom = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (rand_rom) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    case (a)
      32'd0:   return 32'h0002_1020;
      32'd1:   return 32'h0022_1020;
      32'd2:   return 32'h1001_FFFD;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clock) bus.imem_data <= rom_word(bus.imem_sel);

  // Stream model: after a restart the output becomes valid on the second edge and never
  // bubbles again; each accepting edge presents the next sequential PC. Fetch runs one
  // word ahead of the next PC owed to decode once the first issue has happened.
  int          m_cnt;
  logic [31:0] m_nxt;
  logic        m_valid;
  logic [31:0] m_pc;

  task automatic model_reset();
    m_cnt   = 0;
    m_nxt   = ResetPc;
    m_valid = 1'b0;
    m_pc    = 32'h0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] tg);
    if (rd) begin
      m_cnt   = 0;
      m_nxt   = tg;
      m_valid = 1'b0;
    end else begin
      if (m_cnt < 2) m_cnt++;
      if (!m_valid || !st) begin
        if (m_cnt >= 2) begin
          m_valid = 1'b1;
          m_pc    = m_nxt;
          m_nxt   = m_nxt + 32'd1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
    check_eq("imem_sel", bus.imem_sel, m_nxt + ((m_cnt == 0) ? 32'd0 : 32'd1));
    if (m_valid) begin
      check_eq("instr_pc", bus.instr_pc, m_pc);
      check_eq("instr", bus.instr, rom_word(m_pc));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'd0);
    check_eq({tag, "_sel"}, bus.imem_sel, ResetPc);
    check_eq({tag, "_instr"}, bus.instr, 32'd0);
    check_eq({tag, "_pc"}, bus.instr_pc, 32'd0);
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] tg);
    bus.stall           = st;
    bus.redirect        = rd;
    bus.redirect_target = tg;
    @(posedge clock);
    model_edge(st, rd, tg);
    #1;
    check_outputs();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
  endtask

  task automatic run_until(input logic [31:0] pc, input int max_cycles);
    int n = 0;
    while (!(m_valid && m_pc == pc) && n < max_cycles) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    check_eq("reach_valid", {31'b0, bus.instr_valid}, 32'd1);
    check_eq("reach_pc", bus.instr_pc, pc);
  endtask

  initial begin
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("rst");
    reset = 1'b0;

    // Free run: E1 issues, E2 presents pc 0, then 1, 2 back to back.
    step(1'b0, 1'b0, 32'h0);
    check_eq("e1_invalid", {31'b0, bus.instr_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("e2_pc0", bus.instr_pc, 32'd0);
    check_eq("e2_word0", bus.instr, 32'h0002_1020);
    run_until(32'd2, 10);

    // Redirect loop back to 0 while pc 2 is presented.
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("redir_pc0", bus.instr_pc, 32'd0);
    repeat (2) step(1'b0, 1'b0, 32'h0);

    // Stall for 3 cycles while pc 1 is presented, then resume without a bubble.
    step(1'b1, 1'b1, 32'h0);
    run_until(32'd1, 10);
    repeat (3) begin
      step(1'b1, 1'b0, 32'h0);
      check_eq("stall_word", bus.instr, 32'h0022_1020);
    end
    step(1'b0, 1'b0, 32'h0);
    check_eq("release_pc2", bus.instr_pc, 32'd2);
    step(1'b0, 1'b0, 32'h0);
    check_eq("release_pc3", bus.instr_pc, 32'd3);

    // Stall and redirect together: redirect wins.
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h10);
    check_eq("rs_invalid", {31'b0, bus.instr_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rs_pc10", bus.instr_pc, 32'h10);

    // PC wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    check_eq("wrap_top", bus.instr_pc, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'h0);
    check_eq("wrap_zero", bus.instr_pc, 32'h0);

    // Asynchronous reset between edges, mid-stall.
    bus.stall = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_state("arst");
    bus.stall = 1'b0;
    rand_rom  = 1'b1;
    @(posedge clock);
    #1;
    check_reset_state("arst_hold");
    reset = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        st, rd;
      logic [31:0] tg;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 19) == 0);
      tg = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(st, rd, tg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
